// File: rtl/time_counter_pkg.sv
// Shared constants for the time-of-day clock: mode encoding, field width
// and the default terminal values of each field.
package clock_pkg;

  localparam int unsigned FIELD_W     = 6;
  localparam int unsigned SEC_MAX_DEF = 59;
  localparam int unsigned MIN_MAX_DEF = 59;
  localparam int unsigned HR_MAX_DEF  = 23;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_e;

endpackage

// File: rtl/time_counter_mod_counter.sv
// Modulo-(MAX+1) field counter. It advances on en. wrap flags the enabled
// step that returns the count to zero, and feeds the next field's carry.
module mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [FIELD_W-1:0] q,
  output logic               wrap
);

  localparam logic [FIELD_W-1:0] MAX_V = FIELD_W'(MAX);

  logic [FIELD_W-1:0] q_q;
  logic [FIELD_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = (q_q == MAX_V) ? '0 : q_q + FIELD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign wrap = en && (q_q == MAX_V);

endmodule

// File: rtl/time_counter.sv
// Time-of-day counter: tick-driven sec/min/hour chain in RUN. The mode
// FSM selects a single field for button increments and drives the blink strobe.
module time_counter
  import clock_pkg::*;
#(
  parameter int unsigned SEC_MAX = SEC_MAX_DEF,
  parameter int unsigned MIN_MAX = MIN_MAX_DEF,
  parameter int unsigned HR_MAX  = HR_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               btn_mode,
  input  logic               btn_inc,
  output logic [FIELD_W-1:0] sec,
  output logic [FIELD_W-1:0] min,
  output logic [FIELD_W-1:0] hour,
  output logic [1:0]         state,
  output logic               blink
);

  state_e state_q, state_d;
  logic   blink_q, blink_d;
  logic   sec_en, min_en, hour_en;
  logic   sec_wrap, min_wrap, hour_wrap;
  logic   inc_ok;

  // A mode press in the same cycle swallows the increment.
  assign inc_ok = btn_inc && !btn_mode;

  always_comb begin
    sec_en  = 1'b0;
    min_en  = 1'b0;
    hour_en = 1'b0;
    unique case (state_q)
      RUN: begin
        sec_en  = tick;
        min_en  = sec_wrap;
        hour_en = min_wrap;
      end
      SET_HR:  hour_en = inc_ok;
      SET_MIN: min_en  = inc_ok;
      SET_SEC: sec_en  = inc_ok;
      default: ;
    endcase
  end

  mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk  (clk),
    .rst  (rst),
    .en   (sec_en),
    .q    (sec),
    .wrap (sec_wrap)
  );

  mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk  (clk),
    .rst  (rst),
    .en   (min_en),
    .q    (min),
    .wrap (min_wrap)
  );

  mod_counter #(.MAX(HR_MAX)) u_hour (
    .clk  (clk),
    .rst  (rst),
    .en   (hour_en),
    .q    (hour),
    .wrap (hour_wrap)
  );

  always_comb begin
    state_d = state_q;
    if (btn_mode) begin
      unique case (state_q)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        SET_SEC: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Entering RUN or leaving RUN both clear blink; otherwise ticks toggle it in SET states.
  always_comb begin
    blink_d = blink_q;
    if (state_d == RUN || state_q == RUN) begin
      blink_d = 1'b0;
    end else if (tick) begin
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
    end
  end

  assign state = state_q;
  assign blink = blink_q;

  logic unused_wrap;
  assign unused_wrap = hour_wrap;

endmodule

// File: tb/tb_time_counter.sv
// Directed and random checks of time_counter against a seconds-of-day model.
module tb_time_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [5:0] sec, min, hour;
  logic [1:0] state;
  logic       blink;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: time as seconds since midnight, mode 0..3, blink bit.
  int unsigned m_t     = 0;
  int unsigned m_mode  = 0;
  bit          m_blink = 1'b0;

  time_counter #(.SEC_MAX(59), .MIN_MAX(59), .HR_MAX(23)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .state    (state),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  function automatic int unsigned m_h();  return m_t / 3600;       endfunction
  function automatic int unsigned m_m();  return (m_t / 60) % 60;  endfunction
  function automatic int unsigned m_s();  return m_t % 60;         endfunction

  task automatic chk(input string tag, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".sec"},   sec,          6'(m_s()));
    chk({tag, ".min"},   min,          6'(m_m()));
    chk({tag, ".hour"},  hour,         6'(m_h()));
    chk({tag, ".state"}, {4'd0, state}, 6'(m_mode));
    chk({tag, ".blink"}, {5'd0, blink}, {5'd0, m_blink});
  endtask

  task automatic model_reset();
    m_t = 0; m_mode = 0; m_blink = 1'b0;
  endtask

  task automatic model_edge(input bit t, input bit md, input bit inc);
    int unsigned h, m, s;
    h = m_h(); m = m_m(); s = m_s();
    if (m_mode == 0) begin
      if (t) m_t = (m_t + 1) % 86400;
      if (md) begin m_mode = 1; m_blink = 1'b0; end
    end else begin
      if (md) m_mode = (m_mode + 1) % 4;
      else if (inc) begin
        case (m_mode)
          1: h = (h + 1) % 24;
          2: m = (m + 1) % 60;
          default: s = (s + 1) % 60;
        endcase
        m_t = h * 3600 + m * 60 + s;
      end
      if (m_mode == 0) m_blink = 1'b0;
      else if (t) m_blink = ~m_blink;
    end
  endtask

  task automatic step(input bit t, input bit md, input bit inc, input string tag);
    tick = t; btn_mode = md; btn_inc = inc;
    @(posedge clk);
    model_edge(t, md, inc);
    #1;
    tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    chk_all(tag);
  endtask

  // From RUN: walk through the SET states with increments, then back to RUN.
  task automatic set_time(input int unsigned h, input int unsigned m, input int unsigned s);
    step(0, 1, 0, "set.mode");
    for (int unsigned i = 0; i < 24 && m_h() != h; i++) step(0, 0, 1, "set.hr");
    step(0, 1, 0, "set.mode");
    for (int unsigned i = 0; i < 60 && m_m() != m; i++) step(0, 0, 1, "set.min");
    step(0, 1, 0, "set.mode");
    for (int unsigned i = 0; i < 60 && m_s() != s; i++) step(0, 0, 1, "set.sec");
    step(0, 1, 0, "set.run");
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1 chk_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1 chk_all("por");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) step(1, 0, 0, "cnt");
    async_reset("rst_mid_count");
    for (int i = 0; i < 5; i++) step(1, 0, 0, "cnt5");
    chk("five_ticks", sec, 6'd5);

    set_time(0, 0, 59);
    step(1, 0, 0, "min_carry");
    chk("min_carry.min", min, 6'd1);

    set_time(23, 59, 59);
    step(1, 0, 0, "rollover");
    chk("rollover.h", hour, 6'd0);

    set_time(10, 20, 30);
    step(0, 1, 0, "to_set_hr");
    for (int i = 0; i < 14; i++) step(0, 0, 1, "hr_inc");
    chk("hr_wrap", hour, 6'd0);
    chk("hr_wrap.min", min, 6'd20);
    for (int i = 0; i < 100; i++) step(1, 0, 0, "frozen");
    chk("frozen.sec", sec, 6'd30);
    for (int i = 0; i < 3; i++) step(0, 1, 0, "back_run");
    chk("back_run.blink", {5'd0, blink}, 6'd0);

    set_time(5, 59, 0);
    step(0, 1, 0, "s.hr");
    step(0, 1, 0, "s.min");
    step(1, 1, 1, "mode_inc");
    chk("mode_inc.min", min, 6'd59);
    step(0, 1, 0, "s.run");

    set_time(5, 10, 10);
    step(1, 1, 0, "tick_mode");
    chk("tick_mode.sec", sec, 6'd11);

    step(0, 1, 0, "s.min2");
    step(0, 1, 0, "s.sec2");
    for (int i = 0; i < 60 && m_s() != 45; i++) step(i[0], 0, 1, "s.sec45");
    async_reset("rst_mid_set");

    for (int i = 0; i < 800; i++) begin
      step(($urandom % 2) == 0, ($urandom % 8) == 0, ($urandom % 3) == 0, "rand");
      if (($urandom % 200) == 0) async_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/time_counter.md
# time_counter

Time-of-day counter for the digital clock. Counts seconds, minutes and hours from a 1 Hz enable pulse and lets the user set the time with two button pulses. Its 6-bit `sec`, `min` and `hour` outputs each feed a 6-bit comparator stage, which splits a value into tens-digit and select codes for the display path.

## Interface

Parameters:

- `SEC_MAX`, default 59 — terminal value of the seconds field.
- `MIN_MAX`, default 59 — terminal value of the minutes field.
- `HR_MAX`, default 23 — terminal value of the hours field.

Ports:

- `clk` — input, 1 — system clock. All state changes on its rising edge.
- `rst` — input, 1 — reset. **Asynchronous, active-high.** Single clock domain.
- `tick` — input, 1 — single-cycle 1 Hz enable pulse from the prescaler.
- `btn_mode` — input, 1 — single-cycle pulse from a debounced, edge-detected button.
- `btn_inc` — input, 1 — single-cycle pulse from a debounced, edge-detected button.
- `sec` — output, 6 — seconds, 0..SEC_MAX.
- `min` — output, 6 — minutes, 0..MIN_MAX.
- `hour` — output, 6 — hours, 0..HR_MAX.
- `state` — output, 2 — mode: RUN=0, SET_HR=1, SET_MIN=2, SET_SEC=3.
- `blink` — output, 1 — display blank strobe for the field being set.

## Operation

- Reset values: `sec`=0, `min`=0, `hour`=0, `state`=RUN, `blink`=0.
- FSM on `btn_mode`: RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN. One transition per pulse.
- RUN state:
  - `tick`=1 increments `sec`.
  - `sec`==SEC_MAX wraps to 0 and increments `min` on the same edge.
  - `min`==MIN_MAX together with the seconds carry wraps to 0 and increments `hour`.
  - `hour`==HR_MAX with a carry wraps to 0. 23:59:59 + tick -> 00:00:00.
  - `btn_inc` is ignored.
- SET_* states:
  - `tick` does not advance time. The clock is frozen.
  - `btn_inc` increments only the selected field, modulo (MAX+1), with no carry into any other field.
- Simultaneous events:
  - `btn_mode` and `btn_inc` in the same cycle: the mode change wins and the inc is dropped.
  - `tick` and `btn_mode` in RUN: the tick is applied and the state advances on the same edge.
  - `tick` and `btn_inc` in a SET state: the inc is applied and the tick only drives `blink`.
- `blink`:
  - Toggles on every `tick` while in a SET state.
  - Forced to 0 on the edge that enters RUN.
  - Resets to 0 on entering SET_HR from RUN.
- Out-of-range values are never produced. Each field saturates its compare at `==MAX` only. Fields are always loaded with in-range values.
- All arithmetic is unsigned, 6-bit, and never wider than the field.
- Reset mid-set: outputs return to reset values immediately, without waiting for `clk`.

## Timing

- Latency is 1 cycle. An input pulse sampled on edge N is visible on the outputs after edge N.
- Outputs are registered. There are no combinational paths from inputs to outputs.
- Input pulses are assumed one cycle wide. A pulse held for k cycles is treated as k events; the debouncer guarantees single-cycle pulses.
- Carry ripple sec -> min -> hour completes on one edge. No intermediate value is ever visible.
- `rst` is asserted asynchronously and released synchronously by the top-level reset synchroniser.

## Structure

- Shared package `clock_pkg` holds:
  - the state encoding constants RUN, SET_HR, SET_MIN, SET_SEC;
  - the defaults 59/59/23;
  - the field width 6.
- One natural sub-module, `mod_counter`:
  - Parameter: MAX.
  - Inputs: `clk`, `rst`, `en`.
  - Outputs: `q`[5:0] and `wrap` (combinational, `en && q==MAX`).
  - Instantiated three times.
  - In RUN, `en` is driven by the tick/carry chain. In a SET state, it is driven by `btn_inc` gated with the field select.
- The FSM and `blink` toggle live in `time_counter` itself.

## Test plan

- **Reset and seconds count:** assert `rst` mid-count, then release and apply 5 `tick` pulses.
  - Outputs are 0/0/0 and RUN immediately on `rst`, without a clock edge.
  - After the ticks, `sec`=5.
- **Minute carry:** preset to 00:00:59, then apply one `tick`.
  - Result is `sec`=0, `min`=1, `hour`=0.
- **Day rollover:** preset to 23:59:59, then apply one `tick`.
  - Result is 00:00:00 with no intermediate values.
- **Set sequence:**
  - From RUN at 10:20:30, one `btn_mode` gives SET_HR.
  - 14 `btn_inc` pulses give `hour`=0, with no change to `min`. Wrap is 23->0.
  - 100 `tick` pulses leave `sec`=30 and toggle `blink` 100 times.
  - 3 more `btn_mode` pulses return to RUN with `blink`=0.
- **Simultaneous events:**
  - `btn_mode`+`btn_inc` in SET_MIN at `min`=59 gives SET_SEC with `min` still 59.
  - `tick`+`btn_mode` in RUN at `sec`=10 gives `sec`=11 and SET_HR.
- **Reset mid-set:** in SET_SEC with `sec`=45, pulse `rst` asynchronously between clock edges.
  - Outputs go to 0/0/0, RUN and `blink`=0 before the next edge.
